hour_control: RTL and testbench

//  Hour stage of the digital clock; sits directly downstream of the minute stage.

---
 rtl/hour_control_if.sv | 31 +++
 rtl/hour_control.sv | 117 +++++++++++
 tb/tb_hour_control.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hour_control_if.sv
// Hour stage bundle: controls from the minute stage / set panel,
// BCD display and day-rollover pulse back out.
interface hour_control_if;
  logic       set_ena;
  logic       up;
  logic       down;
  logic       TC_from_minute;
  logic [7:0] BCD_out;
  logic       pm;
  logic       TC_to_day;

  modport master (
    output set_ena,
    output up,
    output down,
    output TC_from_minute,
    input  BCD_out,
    input  pm,
    input  TC_to_day
  );

  modport slave (
    input  set_ena,
    input  up,
    input  down,
    input  TC_from_minute,
    output BCD_out,
    output pm,
    output TC_to_day
  );
endinterface

// File: rtl/hour_control.sv
// Hour stage of the digital clock: binary hour 0..23 with registered
// BCD (24h or 12h+pm) decode, manual set and day-rollover pulse.
module hour_control #(
  parameter bit MODE_24     = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  hour_control_if.slave bus
);

  localparam logic [7:0] RST_BCD =
    MODE_24 ? 8'h00 : 8'h12;

  logic [SYNC_STAGES-1:0] tc_s;
  logic [SYNC_STAGES-1:0] up_s;
  logic [SYNC_STAGES-1:0] dn_s;
  logic tc_q;
  logic up_q;
  logic dn_q;
  logic tc_ev;
  logic up_ev;
  logic dn_ev;

  logic [4:0] h;
  logic [4:0] h_nx;
  logic       roll;
  logic [7:0] bcd_q;
  logic       pm_q;
  logic       day_q;

  logic [4:0] v;
  logic [3:0] t;
  logic [3:0] u;
  logic       dec_pm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tc_s <= '0;
      up_s <= '0;
      dn_s <= '0;
      tc_q <= 1'b0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      tc_s <= {tc_s[SYNC_STAGES-2:0],
               bus.TC_from_minute};
      up_s <= {up_s[SYNC_STAGES-2:0], bus.up};
      dn_s <= {dn_s[SYNC_STAGES-2:0], bus.down};
      tc_q <= tc_s[SYNC_STAGES-1];
      up_q <= up_s[SYNC_STAGES-1];
      dn_q <= dn_s[SYNC_STAGES-1];
    end
  end

  assign tc_ev = tc_s[SYNC_STAGES-1] & ~tc_q;
  assign up_ev = up_s[SYNC_STAGES-1] & ~up_q;
  assign dn_ev = dn_s[SYNC_STAGES-1] & ~dn_q;

  // Events are consumed every edge, so a TC seen in set mode is lost.
  always_comb begin
    h_nx = h;
    roll = 1'b0;
    unique case (1'b1)
      !bus.set_ena && tc_ev: begin
        roll = (h == 5'd23);
        h_nx = roll ? 5'd0 : h + 5'd1;
      end
      bus.set_ena && up_ev && !dn_ev:
        h_nx = (h == 5'd23) ? 5'd0 : h + 5'd1;
      bus.set_ena && dn_ev && !up_ev:
        h_nx = (h == 5'd0) ? 5'd23 : h - 5'd1;
      default: ;
    endcase
  end

  always_comb begin
    v      = h_nx;
    dec_pm = 1'b0;
    t      = 4'd0;
    u      = 4'd0;
    if (!MODE_24) begin
      dec_pm = (h_nx >= 5'd12);
      if (dec_pm) v = h_nx - 5'd12;
      if (v == 5'd0) v = 5'd12;
    end
    if (v >= 5'd20) begin
      t = 4'd2;
      u = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      t = 4'd1;
      u = 4'(v - 5'd10);
    end else begin
      t = 4'd0;
      u = v[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h     <= 5'd0;
      bcd_q <= RST_BCD;
      pm_q  <= 1'b0;
      day_q <= 1'b0;
    end else begin
      h     <= h_nx;
      bcd_q <= {t, u};
      pm_q  <= dec_pm;
      day_q <= roll;
    end
  end

  assign bus.BCD_out   = bcd_q;
  assign bus.pm        = pm_q;
  assign bus.TC_to_day = day_q;

endmodule

// File: tb/tb_hour_control.sv
// Bench for hour_control: 24h and 12h instances share stimulus and
// are checked against an arithmetic hour model.
module tb_hour_control;

  logic clk = 1'b0;
  logic reset_n;
  logic set_ena;
  logic up;
  logic down;
  logic tc;

  always #5 clk = ~clk;

  hour_control_if if24 ();
  hour_control_if if12 ();

  assign if24.set_ena        = set_ena;
  assign if24.up             = up;
  assign if24.down           = down;
  assign if24.TC_from_minute = tc;
  assign if12.set_ena        = set_ena;
  assign if12.up             = up;
  assign if12.down           = down;
  assign if12.TC_from_minute = tc;

  hour_control #(.MODE_24(1'b1), .SYNC_STAGES(2)) u24 (
    .clk(clk), .reset_n(reset_n), .bus(if24.slave)
  );

  hour_control #(.MODE_24(1'b0), .SYNC_STAGES(2)) u12 (
    .clk(clk), .reset_n(reset_n), .bus(if12.slave)
  );

  int total = 0;
  int bad   = 0;
  int day24 = 0;
  int day12 = 0;

  always @(negedge clk) begin
    if (if24.TC_to_day === 1'b1) day24++;
    if (if12.TC_to_day === 1'b1) day12++;
  end

  typedef struct {
    bit         set;
    int         op;
    int         reps;
    logic [7:0] b24;
    logic [7:0] b12;
    bit         pm;
    int         day;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [7:0] e24(int h);
    return 8'(((h / 10) * 16) + (h % 10));
  endfunction

  function automatic logic [7:0] e12(int h);
    int v;
    v = (h % 12 == 0) ? 12 : h % 12;
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int op, input logic v);
    case (op)
      0: tc = v;
      1: up = v;
      2: down = v;
      default: begin
        up   = v;
        down = v;
      end
    endcase
  endtask

  task automatic pulse(input int op, input int hi, input int lo);
    @(negedge clk);
    drive(op, 1'b1);
    repeat (hi) @(negedge clk);
    drive(op, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  task automatic set_mode(input logic s);
    if (set_ena !== s) begin
      @(negedge clk);
      set_ena = s;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic check_state(input string tag, input int h);
    chk({tag, "_b24"}, 32'(if24.BCD_out), 32'(e24(h)));
    chk({tag, "_b12"}, 32'(if12.BCD_out), 32'(e12(h)));
    chk({tag, "_pm12"}, 32'(if12.pm), 32'(h >= 12));
    chk({tag, "_pm24"}, 32'(if24.pm), 32'd0);
  endtask

  initial begin
    int d24;
    int d12;
    int mh;
    int op;
    int hi;
    bit s;
    bit roll;

    tbl[0]  = '{1'b0, 0, 11, 8'h11, 8'h11, 1'b0, 0};
    tbl[1]  = '{1'b0, 0, 1,  8'h12, 8'h12, 1'b1, 0};
    tbl[2]  = '{1'b0, 0, 11, 8'h23, 8'h11, 1'b1, 0};
    tbl[3]  = '{1'b0, 0, 1,  8'h00, 8'h12, 1'b0, 1};
    tbl[4]  = '{1'b1, 2, 1,  8'h23, 8'h11, 1'b1, 0};
    tbl[5]  = '{1'b1, 1, 1,  8'h00, 8'h12, 1'b0, 0};
    tbl[6]  = '{1'b1, 0, 3,  8'h00, 8'h12, 1'b0, 0};
    tbl[7]  = '{1'b1, 3, 1,  8'h00, 8'h12, 1'b0, 0};
    tbl[8]  = '{1'b1, 1, 5,  8'h05, 8'h05, 1'b0, 0};
    tbl[9]  = '{1'b0, 1, 2,  8'h05, 8'h05, 1'b0, 0};
    tbl[10] = '{1'b0, 0, 3,  8'h08, 8'h08, 1'b0, 0};
    tbl[11] = '{1'b0, 2, 1,  8'h08, 8'h08, 1'b0, 0};

    reset_n = 1'b0;
    set_ena = 1'b0;
    up      = 1'b0;
    down    = 1'b0;
    tc      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_b24", 32'(if24.BCD_out), 32'h00);
    chk("rst_b12", 32'(if12.BCD_out), 32'h12);
    chk("rst_pm12", 32'(if12.pm), 32'd0);
    chk("rst_day", 32'(if24.TC_to_day), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 24 minute terminal counts, last one timed exactly
    for (int i = 1; i < 24; i++) begin
      pulse(0, 4, 6);
      check_state("t1", i);
    end
    d24 = day24;
    @(negedge clk);
    tc = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t1_day_k1", 32'(if24.TC_to_day), 32'd0);
    chk("t1_b_k1", 32'(if24.BCD_out), 32'h23);
    @(posedge clk);
    #1;
    chk("t1_day_k2", 32'(if24.TC_to_day), 32'd1);
    chk("t1_day12_k2", 32'(if12.TC_to_day), 32'd1);
    chk("t1_b_k2", 32'(if24.BCD_out), 32'h00);
    chk("t1_b12_k2", 32'(if12.BCD_out), 32'h12);
    @(posedge clk);
    #1;
    chk("t1_day_k3", 32'(if24.TC_to_day), 32'd0);
    @(negedge clk);
    tc = 1'b0;
    repeat (6) @(negedge clk);
    chk("t1_daycnt", 32'(day24 - d24), 32'd1);

    for (int r = 0; r < 12; r++) begin
      set_mode(tbl[r].set);
      d24 = day24;
      d12 = day12;
      repeat (tbl[r].reps) pulse(tbl[r].op, 2, 4);
      chk($sformatf("tbl%0d_b24", r),
          32'(if24.BCD_out), 32'(tbl[r].b24));
      chk($sformatf("tbl%0d_b12", r),
          32'(if12.BCD_out), 32'(tbl[r].b12));
      chk($sformatf("tbl%0d_pm", r),
          32'(if12.pm), 32'(tbl[r].pm));
      chk($sformatf("tbl%0d_d24", r),
          32'(day24 - d24), 32'(tbl[r].day));
      chk($sformatf("tbl%0d_d12", r),
          32'(day12 - d12), 32'(tbl[r].day));
    end

    // same-cycle up/down, then a long up hold
    set_mode(1'b1);
    pulse(3, 3, 4);
    check_state("t4_both", 8);
    pulse(1, 50, 4);
    check_state("t4_hold", 9);

    // reset during a pending update at 17
    set_mode(1'b0);
    repeat (8) pulse(0, 3, 5);
    check_state("t5_pre", 17);
    d24 = day24;
    @(negedge clk);
    tc = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_b24", 32'(if24.BCD_out), 32'h00);
    chk("t5_async_b12", 32'(if12.BCD_out), 32'h12);
    chk("t5_async_pm", 32'(if12.pm), 32'd0);
    chk("t5_async_day", 32'(if24.TC_to_day), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_state("t5_rel", 1);
    tc = 1'b0;
    repeat (4) @(negedge clk);
    check_state("t5_post", 1);
    chk("t5_day", 32'(day24 - d24), 32'd0);

    mh = 1;
    for (int n = 0; n < 150; n++) begin
      s  = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 5));
      if (op > 3) op = 0;
      hi = int'($urandom_range(1, 5));
      set_mode(s);
      d24 = day24;
      d12 = day12;
      pulse(op, hi, 4);
      roll = 1'b0;
      if (!s) begin
        if (op == 0) begin
          roll = (mh == 23);
          mh   = (mh + 1) % 24;
        end
      end else if (op == 1) begin
        mh = (mh + 1) % 24;
      end else if (op == 2) begin
        mh = (mh + 23) % 24;
      end
      check_state($sformatf("rnd%0d", n), mh);
      chk($sformatf("rnd%0d_d24", n),
          32'(day24 - d24), 32'(roll));
      chk($sformatf("rnd%0d_d12", n),
          32'(day12 - d12), 32'(roll));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
